bin2csd_seq: RTL and testbench

- Sequential encoder from W-bit two's-complement binary to canonical signed digit (CSD, non-adjacent form). It is the inverse of the csd2bin decoder.
- The output uses the same 2-bit-per-digit CSD bus format that csd2bin consumes, so bin2csd_seq feeding csd2bin gives back the original value.
- It generates DPC digits per clock, LSB first, between valid/ready handshakes. It sits at the FPU BKM operand-encoding input.

---
 rtl/bin2csd_seq.sv | 115 +++++++++++
 tb/tb_bin2csd_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2csd_seq.sv
// Sequential binary -> CSD (non-adjacent form) encoder, DPC digits per clock, LSB first.
// Optional BIN2CSD_NZCNT_EN adds an nzcnt output counting nonzero digits of y.
module bin2csd_seq #(
  parameter int W   = 73,
  parameter int DPC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y
`ifdef BIN2CSD_NZCNT_EN
  ,
  output logic [$clog2(W+1)-1:0] nzcnt
`endif
);

  localparam int CW = $clog2(W + DPC + 1);
  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e              state_q;
  logic signed [W:0]   v_q, v_d;
  logic [2*W-1:0]      y_q, y_d;
  logic [CW-1:0]       cnt_q;
  logic                in_ready_q, out_valid_q;
`ifdef BIN2CSD_NZCNT_EN
  localparam int NZW = $clog2(W + 1);
  logic [NZW-1:0]      nz_q, nz_d;
`endif

  // Digit chain: v is W+1 bits so v+1 from 2^(W-1)-1 cannot overflow.
  always_comb begin
    logic signed [W:0] vt;
    logic [CW-1:0]     idx;
    vt  = v_q;
    y_d = y_q;
    idx = cnt_q;
`ifdef BIN2CSD_NZCNT_EN
    nz_d = nz_q;
`endif
    for (int j = 0; j < DPC; j++) begin
      idx = cnt_q + CW'(j);
      if (vt[0]) begin
        if (idx < CW'(W)) begin
          y_d[2*idx +: 2] = {vt[1], 1'b1};
`ifdef BIN2CSD_NZCNT_EN
          nz_d = nz_d + NZW'(1);
`endif
        end
        vt = vt[1] ? vt + ONE : vt - ONE;
      end
      vt = vt >>> 1;
    end
    v_d = vt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      v_q         <= '0;
      cnt_q       <= '0;
`ifdef BIN2CSD_NZCNT_EN
      nz_q        <= '0;
`endif
    end else if (ena) begin
      case (state_q)
        IDLE: if (in_valid) begin
          v_q        <= {x[W-1], x};
          y_q        <= '0;
          cnt_q      <= '0;
`ifdef BIN2CSD_NZCNT_EN
          nz_q       <= '0;
`endif
          in_ready_q <= 1'b0;
          state_q    <= CONV;
        end
        CONV: begin
          v_q   <= v_d;
          y_q   <= y_d;
          cnt_q <= cnt_q + CW'(DPC);
`ifdef BIN2CSD_NZCNT_EN
          nz_q  <= nz_d;
`endif
          if (cnt_q + CW'(DPC) >= CW'(W)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
`ifdef BIN2CSD_NZCNT_EN
  assign nzcnt     = nz_q;
`endif

endmodule

// File: tb/tb_bin2csd_seq.sv
// Bench for bin2csd_seq: four instances (W=8/73, DPC=1/3/4) driven in lockstep,
// checked against an arithmetic NAF model and a CSD decode round trip.
module tb_bin2csd_seq;

  logic         clk = 1'b0;
  logic         rst, ena, in_valid, out_ready;
  logic [72:0]  x;
  logic [3:0]   rdy, ov;
  logic [15:0]  ya, yb;
  logic [145:0] yc, yd;
  int vectors = 0;
  int miscompares = 0;
`ifdef BIN2CSD_NZCNT_EN
  logic [3:0] nza, nzb;
  logic [6:0] nzc, nzd;
`endif

  always #5 clk = ~clk;

  bin2csd_seq #(.W(8), .DPC(1)) u_a (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy[0]), .x(x[7:0]),
    .out_valid(ov[0]), .out_ready(out_ready), .y(ya)
`ifdef BIN2CSD_NZCNT_EN
    , .nzcnt(nza)
`endif
  );
  bin2csd_seq #(.W(8), .DPC(3)) u_b (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy[1]), .x(x[7:0]),
    .out_valid(ov[1]), .out_ready(out_ready), .y(yb)
`ifdef BIN2CSD_NZCNT_EN
    , .nzcnt(nzb)
`endif
  );
  bin2csd_seq #(.W(73), .DPC(1)) u_c (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy[2]), .x(x),
    .out_valid(ov[2]), .out_ready(out_ready), .y(yc)
`ifdef BIN2CSD_NZCNT_EN
    , .nzcnt(nzc)
`endif
  );
  bin2csd_seq #(.W(73), .DPC(4)) u_d (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy[3]), .x(x),
    .out_valid(ov[3]), .out_ready(out_ready), .y(yd)
`ifdef BIN2CSD_NZCNT_EN
    , .nzcnt(nzd)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // NAF from the 3x/2 identity: +1 where (x+x/2) has a bit that x/2 lacks, -1 the reverse.
  function automatic logic [159:0] naf(input logic signed [79:0] xv, input int w);
    logic signed [79:0] xh, x3, c;
    logic [159:0] r;
    xh = xv >>> 1;
    x3 = xv + xh;
    c  = xh ^ x3;
    r  = '0;
    for (int i = 0; i < w; i++)
      if (x3[i] & c[i]) r[2*i +: 2] = 2'b01;
      else if (xh[i] & c[i]) r[2*i +: 2] = 2'b11;
    return r;
  endfunction

  function automatic logic signed [79:0] dec(input logic [159:0] yv, input int w);
    logic signed [79:0] s;
    s = '0;
    for (int i = 0; i < w; i++)
      if (yv[2*i +: 2] == 2'b01) s = s + (80'sd1 <<< i);
      else if (yv[2*i +: 2] == 2'b11) s = s - (80'sd1 <<< i);
    return s;
  endfunction

  function automatic logic naf_ok(input logic [159:0] yv, input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < w; i++) begin
      if (yv[2*i +: 2] == 2'b10) ok = 1'b0;
      if (i > 0 && yv[2*i] && yv[2*i-2]) ok = 1'b0;
    end
    return ok;
  endfunction

`ifdef BIN2CSD_NZCNT_EN
  function automatic int nzn(input logic [159:0] yv, input int w);
    int n;
    n = 0;
    for (int i = 0; i < w; i++) if (yv[2*i]) n++;
    return n;
  endfunction
`endif

  task automatic run(input logic [72:0] xv, input int stall_at, input bit hold);
    int lat[4];
    int cyc;
    logic signed [79:0] s8, s73;
    s8  = {{72{xv[7]}}, xv[7:0]};
    s73 = {{7{xv[72]}}, xv};
    x = xv;
    in_valid = 1'b1;
    tick();
    chk("accept_in_ready", rdy, 4'h0);
    // keep in_valid up with junk x: must be ignored outside IDLE
    x = {$urandom, $urandom, $urandom};
    lat = '{0, 0, 0, 0};
    cyc = 0;
    while (ov != 4'hf && cyc < 200) begin
      if (cyc == stall_at) begin
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
      end
      tick();
      cyc++;
      for (int k = 0; k < 4; k++) if (ov[k] && lat[k] == 0) lat[k] = cyc;
    end
    chk("lat_w8_d1", lat[0], 8);
    chk("lat_w8_d3", lat[1], 3);
    chk("lat_w73_d1", lat[2], 73);
    chk("lat_w73_d4", lat[3], 19);
    if (hold) begin
      repeat (20) tick();
      chk("hold_in_ready", rdy, 4'h0);
      chk("hold_out_valid", ov, 4'hf);
    end
    in_valid = 1'b0;
    chk("y_w8_d1", ya, naf(s8, 8));
    chk("y_w8_d3", yb, naf(s8, 8));
    chk("y_w73_d1", yc, naf(s73, 73));
    chk("y_w73_d4", yd, naf(s73, 73));
    chk("rt_w73_d1", dec(yc, 73), s73);
    chk("rt_w73_d4", dec(yd, 73), s73);
    chk("naf_w73_d1", naf_ok(yc, 73), 1'b1);
    chk("naf_w73_d4", naf_ok(yd, 73), 1'b1);
`ifdef BIN2CSD_NZCNT_EN
    chk("nz_w8_d1", nza, nzn(naf(s8, 8), 8));
    chk("nz_w8_d3", nzb, nzn(naf(s8, 8), 8));
    chk("nz_w73_d1", nzc, nzn(naf(s73, 73), 73));
    chk("nz_w73_d4", nzd, nzn(naf(s73, 73), 73));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_out_valid", ov, 4'h0);
    chk("release_in_ready", rdy, 4'hf);
  endtask

  initial begin
    logic [72:0] dir[9];
    rst = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0;
    repeat (2) tick();
    chk("rst_in_ready", rdy, 4'hf);
    chk("rst_out_valid", ov, 4'h0);
    chk("rst_y_a", ya, 16'h0);
    chk("rst_y_d", yd, 146'h0);
    rst = 1'b1;
    tick();

    dir[0] = 73'h07;                  // 8-bit: +8 -1
    dir[1] = 73'h80;                  // 8-bit: -128
    dir[2] = 73'h7F;                  // 8-bit: max positive
    dir[3] = {73{1'b1}};              // -1 everywhere
    dir[4] = 73'h55;
    dir[5] = 73'h0;
    dir[6] = {1'b1, 72'h0};           // 73-bit most negative
    dir[7] = {1'b0, {72{1'b1}}};      // 73-bit most positive
    dir[8] = {1'b0, {36{2'b01}}};
    for (int i = 0; i < 9; i++) run(dir[i], (i == 2) ? 2 : -1, i == 3);

    for (int i = 0; i < 20; i++)
      run({$urandom, $urandom, $urandom}, (i == 5) ? 1 : -1, i == 11);

    // reset mid-conversion with ena low: operand dropped, state cleared
    x = 73'h15;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    ena = 1'b0;
    tick();
    chk("midrst_out_valid", ov, 4'h0);
    chk("midrst_in_ready", rdy, 4'hf);
    chk("midrst_y_a", ya, 16'h0);
    chk("midrst_y_c", yc, 146'h0);
    rst = 1'b1;
    ena = 1'b1;
    tick();
    run(73'h1234_5678_9abc_def0_1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
